// File: rtl/song_menu_ctrl.sv
// rtl/song_menu_ctrl.sv - button synchronise/debounce front end and title/menu/play state machine
module song_menu_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_SONGS       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       btn_ok_raw,
    input  logic       btn_back_raw,
    input  logic       game_over,
    output logic       menu_enabled,
    output logic [1:0] song,
    output logic       start_game,
    output logic [1:0] state_dbg
);

    localparam int              CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE_CYCLES);
    localparam logic [1:0]      LAST_SONG = 2'(NUM_SONGS - 1);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        MENU  = 2'd1,
        START = 2'd2,
        PLAY  = 2'd3
    } state_t;

    // Bit order for all button vectors: 0=up, 1=down, 2=ok, 3=back
    logic [3:0]    btn_raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    stable_q;
    logic [3:0]    press;
    logic [CW-1:0] cnt [4];

    state_t     state;
    state_t     state_next;
    logic [1:0] song_next;
    logic       menu_next;
    logic       start_next;

    assign btn_raw = {btn_back_raw, btn_ok_raw, btn_down_raw, btn_up_raw};

    // Two-flop synchroniser followed by a per-button stability counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // One-cycle press event on each rising edge of a debounced level
    assign press = stable & ~stable_q;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= TITLE;
            song         <= 2'd0;
            menu_enabled <= 1'b0;
            start_game   <= 1'b0;
        end else begin
            state        <= state_next;
            song         <= song_next;
            menu_enabled <= menu_next;
            start_game   <= start_next;
        end
    end

    // Next-state: ok outranks back, START is a single pass-through cycle
    always_comb begin
        state_next = state;
        case (state)
            TITLE: if (|press)      state_next = MENU;
            MENU: begin
                if (press[2])       state_next = START;
                else if (press[3])  state_next = TITLE;
            end
            START:                  state_next = PLAY;
            PLAY:  if (game_over)   state_next = MENU;
            default:                state_next = TITLE;
        endcase
    end

    // Output decode: song moves only on a lone up or down press while in MENU
    always_comb begin
        song_next  = song;
        menu_next  = (state_next == MENU);
        start_next = (state_next == START);
        if (state == MENU && !press[2] && !press[3] && (press[0] ^ press[1])) begin
            if (press[0]) begin
                song_next = (song >= LAST_SONG) ? 2'd0 : song + 2'd1;
            end else begin
                song_next = (song == 2'd0 || song > LAST_SONG) ? LAST_SONG : song - 2'd1;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_song_menu_ctrl.sv
// tb/tb_song_menu_ctrl.sv - randomized scoreboard bench for song_menu_ctrl
module tb_song_menu_ctrl;

    localparam int D = 4;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up_raw, btn_down_raw, btn_ok_raw, btn_back_raw;
    logic       game_over;
    logic       menu_enabled;
    logic [1:0] song;
    logic       start_game;
    logic [1:0] state_dbg;

    int n_pass  = 0;
    int n_total = 0;

    logic [5:0] exp_q[$];
    logic [5:0] last_snap = 6'd0;
    logic [5:0] prev_snap = 6'd0;
    logic [5:0] cur_snap;
    logic [5:0] exp_snap;
    bit         mon_en = 1'b0;

    int m_state = 0;
    int m_song  = 0;

    song_menu_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_SONGS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .btn_ok_raw   (btn_ok_raw),
        .btn_back_raw (btn_back_raw),
        .game_over    (game_over),
        .menu_enabled (menu_enabled),
        .song         (song),
        .start_game   (start_game),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Snapshot = {state, song, menu_enabled, start_game}; only changes are queued
    task automatic push_snap(input int st, input int sg);
        logic [5:0] s;
        s = {2'(st), 2'(sg), (st == 1), (st == 2)};
        if (s != last_snap) begin
            exp_q.push_back(s);
            last_snap = s;
        end
    endtask

    // Behavioural menu model acting on a set of simultaneous press events
    task automatic model_press(input bit up, input bit dn, input bit ok, input bit bk);
        if (m_state == 0) begin
            if (up || dn || ok || bk) begin
                m_state = 1;
                push_snap(m_state, m_song);
            end
        end else if (m_state == 1) begin
            if (ok) begin
                push_snap(2, m_song);
                m_state = 3;
                push_snap(m_state, m_song);
            end else if (bk) begin
                m_state = 0;
                push_snap(m_state, m_song);
            end else if (up && !dn) begin
                m_song = (m_song + 1) % N;
                push_snap(m_state, m_song);
            end else if (dn && !up) begin
                m_song = (m_song + N - 1) % N;
                push_snap(m_state, m_song);
            end
        end
    endtask

    task automatic press_btns(input bit up, input bit dn, input bit ok, input bit bk);
        int hold;
        hold = D + 1 + int'($urandom_range(0, 6));
        model_press(up, dn, ok, bk);
        @(negedge clk);
        btn_up_raw = up; btn_down_raw = dn; btn_ok_raw = ok; btn_back_raw = bk;
        repeat (hold) @(negedge clk);
        btn_up_raw = 0; btn_down_raw = 0; btn_ok_raw = 0; btn_back_raw = 0;
        repeat (D + 8) @(negedge clk);
    endtask

    task automatic glitch(input int which, input int len);
        @(negedge clk);
        case (which)
            0: btn_up_raw = 1;
            1: btn_down_raw = 1;
            2: btn_ok_raw = 1;
            default: btn_back_raw = 1;
        endcase
        repeat (len) @(negedge clk);
        btn_up_raw = 0; btn_down_raw = 0; btn_ok_raw = 0; btn_back_raw = 0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic pulse_game_over();
        if (m_state == 3) begin
            m_state = 1;
            push_snap(m_state, m_song);
        end
        @(negedge clk);
        game_over = 1;
        @(negedge clk);
        game_over = 0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every visible output change must match the next queued expectation
    always @(negedge clk) begin
        if (mon_en) begin
            cur_snap = {state_dbg, song, menu_enabled, start_game};
            if (cur_snap != prev_snap) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_change: got %b expected no change from %b", cur_snap, prev_snap);
                end else begin
                    exp_snap = exp_q.pop_front();
                    check("output_change", int'(cur_snap), int'(exp_snap));
                end
                prev_snap = cur_snap;
            end
        end
    end

    initial begin
        rst_n = 0;
        btn_up_raw = 0; btn_down_raw = 0; btn_ok_raw = 0; btn_back_raw = 0;
        game_over = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_menu_enabled", int'(menu_enabled), 0);
        check("rst_song", int'(song), 0);
        check("rst_start_game", int'(start_game), 0);
        check("rst_state", int'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;

        // Title -> menu latency on a held ok press
        model_press(0, 0, 1, 0);
        btn_ok_raw = 1;
        repeat (D + 3) @(posedge clk);
        #1 check("title_hold_state", int'(state_dbg), 0);
        @(posedge clk);
        #1 check("title_exit_state", int'(state_dbg), 1);
        check("title_exit_menu", int'(menu_enabled), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        btn_ok_raw = 0;
        repeat (D + 8) @(negedge clk);

        // Bouncy up: 3 high, 3 low, 3 high produces no press
        repeat (3) begin @(negedge clk); btn_up_raw = 1; end
        repeat (3) begin @(negedge clk); btn_up_raw = 0; end
        repeat (3) begin @(negedge clk); btn_up_raw = 1; end
        @(negedge clk); btn_up_raw = 0;
        repeat (D + 8) @(negedge clk);
        check("glitch_song", int'(song), 0);

        // Long hold: one increment only
        model_press(1, 0, 0, 0);
        @(negedge clk); btn_up_raw = 1;
        repeat (20) @(negedge clk);
        btn_up_raw = 0;
        repeat (D + 8) @(negedge clk);

        // Wrap-around and simultaneous up/down
        repeat (4) press_btns(1, 0, 0, 0);
        press_btns(0, 1, 0, 0);
        press_btns(1, 1, 0, 0);
        while (m_song != 2) press_btns(1, 0, 0, 0);

        // ok with up at song 2, then ignored presses in PLAY, then return
        press_btns(1, 0, 1, 0);
        press_btns(1, 0, 0, 0);
        press_btns(0, 0, 1, 0);
        pulse_game_over();
        check("return_song", int'(song), 2);

        // Randomized action sequence
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 8))
                0: press_btns(1, 0, 0, 0);
                1: press_btns(0, 1, 0, 0);
                2: press_btns(0, 0, 1, 0);
                3: press_btns(0, 0, 0, 1);
                4: press_btns(1, 1, 0, 0);
                5: press_btns(1, 0, 1, 0);
                6: pulse_game_over();
                7: glitch(int'($urandom_range(0, 3)), int'($urandom_range(1, D - 1)));
                default: press_btns(0, int'($urandom_range(0, 1)) == 1, 0, 1);
            endcase
        end

        // Get back to MENU, then reset in the cycle START would have begun
        while (m_state != 1) begin
            if (m_state == 3) pulse_game_over();
            else press_btns(0, 1, 0, 0);
        end
        @(negedge clk);
        btn_ok_raw = 1;
        repeat (D + 3) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        btn_ok_raw = 0;
        btn_up_raw = 1;
        m_state = 0;
        m_song = 0;
        push_snap(0, 0);
        @(posedge clk);
        #1 check("abort_start_game", int'(start_game), 0);
        check("abort_state", int'(state_dbg), 0);
        check("abort_song", int'(song), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        model_press(1, 0, 0, 0);
        repeat (D + 3) @(posedge clk);
        #1 check("held_thru_rst_wait", int'(state_dbg), 0);
        @(posedge clk);
        #1 check("held_thru_rst_menu", int'(state_dbg), 1);
        check("held_thru_rst_song", int'(song), 0);
        @(negedge clk);
        btn_up_raw = 0;
        repeat (D + 10) @(negedge clk);

        @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/song_menu_ctrl.md
Name: song_menu_ctrl

Overview:
Front-end controller for the song-selection menu. It synchronises and debounces the four board push-buttons and runs the title/menu/play state machine. It produces the menu_enabled and song[1:0] signals consumed by the song-select VGA overlay stage, plus a one-cycle start_game pulse to the game core. It sits directly upstream of the menu video path in the clk domain.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); must be at least 1.
NUM_SONGS, 4, number of selectable songs; legal range 1..4.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
btn_up_raw  input  1  raw up button, asynchronous, active-high
btn_down_raw  input  1  raw down button, asynchronous, active-high
btn_ok_raw  input  1  raw confirm button, asynchronous, active-high
btn_back_raw  input  1  raw back button, asynchronous, active-high
game_over  input  1  one-cycle pulse from the game core when a run ends
menu_enabled  output  1  high while the menu overlay is shown
song  output  2  currently highlighted or selected song index
start_game  output  1  one-cycle pulse launching the selected song
state_dbg  output  2  current state encoding, for debug LEDs

Behaviour:
- Reset (rst_n=0 at a clk edge): state=TITLE, menu_enabled=0, song=0, start_game=0, sync flops=0, debounced levels=0, counters=0. Only one clock domain exists; all registers use synchronous reset.
- Reset asserted mid-operation aborts everything, including a pending start_game, and returns to TITLE. A button held through reset release is treated as a fresh press once it has debounced.
- Each raw button passes through a 2-flop synchroniser, then a debouncer:
  - The counter clears whenever the synced value equals the stable level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES, the stable level takes the synced value and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- Press event = rising edge of the stable level, one cycle wide.
- Latency: define the first clk edge sampling raw=1 as edge 0. With raw held high, the press event is high during the cycle after edge DEBOUNCE_CYCLES+2. The FSM acts on it at that same edge.
- A release shorter than DEBOUNCE_CYCLES produces no new press. A button held indefinitely produces exactly one press.
- State encoding: TITLE=0, MENU=1, START=2, PLAY=3.
- TITLE: menu_enabled=0. Any press event (up, down, ok or back) -> MENU. song is unchanged.
- MENU: menu_enabled=1.
  - ok press -> START; song is frozen.
  - back press -> TITLE.
  - up press alone: song = (song==NUM_SONGS-1) ? 0 : song+1.
  - down press alone: song = (song==0) ? NUM_SONGS-1 : song-1.
  - up and down in the same cycle: no change.
  - Priority when presses coincide: ok > back > up/down. An ok press coinciding with up leaves song unchanged.
- START: start_game=1 for exactly this one cycle, menu_enabled=0, unconditional -> PLAY.
- PLAY: menu_enabled=0. Button presses are ignored, but debouncers keep running. game_over -> MENU with the previous song still highlighted.
- game_over is ignored in TITLE, MENU and START.
- With NUM_SONGS=1, up and down leave song at 0.
- song never exceeds NUM_SONGS-1.
- All outputs are registered. state_dbg mirrors the state register.

Test Plan:
1. Reset and title: rst_n=0 for 3 cycles, then 1, DEBOUNCE_CYCLES=4 -> menu_enabled=0, song=0, start_game=0, state_dbg=0. Press ok held 10 cycles -> state_dbg=1 and menu_enabled=1 at edge 7 after the raw rise.
2. Debounce rejection: DEBOUNCE_CYCLES=4; up pulses high for 3 cycles, low 3, high 3 -> song remains 0. Then hold up 20 cycles -> song=1, exactly one increment.
3. Wrap-around: NUM_SONGS=4 in MENU; 4 discrete up presses -> song sequence 1,2,3,0. Then one down press -> song=3.
4. Simultaneous and priority: up and down pressed in the same cycle -> song unchanged. ok and up in the same cycle with song=2 -> START entered, start_game high for exactly one cycle, song=2, then state_dbg=3.
5. Play and return: in PLAY, presses of up/ok -> no change to song or state. A one-cycle game_over pulse -> state_dbg=1, menu_enabled=1, song=2.
6. Reset mid-operation: assert rst_n=0 in the cycle START would issue -> start_game stays 0, state_dbg=0, song=0. With up held through reset, one press is seen after DEBOUNCE_CYCLES+2 cycles, moving TITLE -> MENU.
